// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one shift-subtract step per clock,
// sign correction on magnitudes, divide-by-zero shortcut.
module div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] LastCnt = CW'(W);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        r_state;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvsr;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;
  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [W-1:0]  w_a_mag;
  logic [W-1:0]  w_b_mag;
  logic [W:0]    w_shift;
  logic [W:0]    w_diff;
  logic [W-1:0]  w_q_fix;
  logic [W-1:0]  w_r_fix;
  logic [W-1:0]  w_dvnd_fix;

  always_comb begin
    w_a_neg    = is_signed & dividend[W-1];
    w_b_neg    = is_signed & divisor[W-1];
    w_a_mag    = w_a_neg ? -dividend : dividend;
    w_b_mag    = w_b_neg ? -divisor : divisor;
    // Borrow out of the W+1-bit subtract means the partial remainder is below the divisor.
    w_shift    = {r_rem, r_quo[W-1]};
    w_diff     = w_shift - {1'b0, r_dvsr};
    w_q_fix    = r_neg_q ? -r_quo : r_quo;
    w_r_fix    = r_neg_r ? -r_rem : r_rem;
    // With a zero divisor no steps run, so r_quo still holds the dividend magnitude.
    w_dvnd_fix = r_neg_r ? -r_quo : r_quo;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_dbz   <= 1'b0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvsr  <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_busy  <= 1'b1;
            // Zero divisor skips straight to the finalize edge.
            r_count <= (divisor == '0) ? LastCnt : '0;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          if (r_count == LastCnt) begin
            if (r_dvsr == '0) begin
              r_quotient  <= '1;
              r_remainder <= w_dvnd_fix;
              r_dbz       <= 1'b1;
            end else begin
              r_quotient  <= w_q_fix;
              r_remainder <= w_r_fix;
            end
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            if (!w_diff[W]) begin
              r_rem <= w_diff[W-1:0];
              r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[W-1:0];
              r_quo <= {r_quo[W-2:0], 1'b0};
            end
            r_count <= r_count + CW'(1);
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
